// File: rtl/riscv_axi_pkg.sv
// riscv_axi_pkg: shared FSM states, AXI response codes and port indices for the arbiter.
package riscv_axi_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/riscv_axi_arb_grant.sv
// riscv_axi_arb_grant: two-input grant with last_grant state.
// RISCV_AXI_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module riscv_axi_arb_grant
   import riscv_axi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic gnt
);
   logic last_grant;
   assign gnt = (req0 && req1) ? ~last_grant : ~req0;
   always_ff @(posedge clk or posedge rst)
      if (rst) last_grant <= PORT1;
`ifdef RISCV_AXI_ARB_RR_EN
      else if (take) last_grant <= gnt;
`else
      // pinned to port 1 so every tie resolves to port 0
      else if (take) last_grant <= PORT1;
`endif
endmodule

// File: rtl/riscv_axi_arbiter.sv
// riscv_axi_arbiter: grants one of two requesters and runs a single AXI4-Lite transaction at a time.
// Define RISCV_AXI_ARB_RR_EN for round-robin arbitration (fixed priority to port 0 otherwise).
module riscv_axi_arbiter
   import riscv_axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic                req0_write,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic [DATA_W-1:0]   req0_wdata,
   input  logic [DATA_W/8-1:0] req0_wstrb,
   output logic                req0_done,
   output logic [DATA_W-1:0]   req0_rdata,
   output logic                req0_err,
   input  logic                req1_valid,
   input  logic                req1_write,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic [DATA_W-1:0]   req1_wdata,
   input  logic [DATA_W/8-1:0] req1_wstrb,
   output logic                req1_done,
   output logic [DATA_W-1:0]   req1_rdata,
   output logic                req1_err,
   output logic                busy,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY
);
   state_t              state_q, state_d;
   logic                gnt, gnt_q, take, wr_sel;
   logic                aw_pend, w_pend, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata0_q, rdata1_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                unused_resp;

   assign take   = (state_q == S_IDLE) && (req0_valid || req1_valid);
   assign wr_sel = gnt ? req1_write : req0_write;
   assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

   riscv_axi_arb_grant u_grant (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0_valid),
      .req1 (req1_valid),
      .take (take),
      .gnt  (gnt)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (take) state_d = wr_sel ? S_WR_ADDR : S_RD_ADDR;
         S_WR_ADDR: if ((!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY)) state_d = S_WR_RESP;
         S_WR_RESP: if (M_AXI_BVALID) state_d = S_DONE;
         S_RD_ADDR: if (M_AXI_ARREADY) state_d = S_RD_DATA;
         S_RD_DATA: if (M_AXI_RVALID) state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   // AW and W pend independently so either may handshake first
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gnt_q    <= PORT0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         aw_pend  <= 1'b0;
         w_pend   <= 1'b0;
         err_q    <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (take) begin
            gnt_q   <= gnt;
            addr_q  <= gnt ? req1_addr : req0_addr;
            wdata_q <= gnt ? req1_wdata : req0_wdata;
            wstrb_q <= gnt ? req1_wstrb : req0_wstrb;
            aw_pend <= wr_sel;
            w_pend  <= wr_sel;
         end
         if (aw_pend && M_AXI_AWREADY) aw_pend <= 1'b0;
         if (w_pend && M_AXI_WREADY) w_pend <= 1'b0;
         if (state_q == S_WR_RESP && M_AXI_BVALID) err_q <= M_AXI_BRESP[1];
         if (state_q == S_RD_DATA && M_AXI_RVALID) begin
            err_q <= M_AXI_RRESP[1];
            if (gnt_q) rdata1_q <= M_AXI_RDATA;
            else       rdata0_q <= M_AXI_RDATA;
         end
      end

   assign busy          = state_q != S_IDLE;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_AWVALID = aw_pend;
   assign M_AXI_WVALID  = w_pend;
   assign M_AXI_BREADY  = state_q == S_WR_RESP;
   assign M_AXI_ARVALID = state_q == S_RD_ADDR;
   assign M_AXI_RREADY  = state_q == S_RD_DATA;
   assign req0_done     = (state_q == S_DONE) && (gnt_q == PORT0);
   assign req1_done     = (state_q == S_DONE) && (gnt_q == PORT1);
   assign req0_err      = req0_done && err_q;
   assign req1_err      = req1_done && err_q;
   assign req0_rdata    = rdata0_q;
   assign req1_rdata    = rdata1_q;
endmodule
